uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single UART transmitter among several on-chip byte-stream sources (sensor formatters, status reporter, debug). Sits between the requesters and the UART TX core in `top`, feeds one byte at a time into the core's start/busy interface and never interleaves bytes of different packets on `tx`.

---
 rtl/uart_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that shares one UART transmitter among NUM_REQ byte-stream sources.
// Optional: define UART_ARB_SRC_TAG_EN to send a TAG_BASE|index byte before every packet.
module uart_tx_arbiter #(
    parameter int         NUM_REQ  = 4,
    parameter logic [7:0] TAG_BASE = 8'hA0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_data,
    output logic                 uart_start,
    input  logic                 uart_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 active
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    // Overlapping low bits would make tags from different sources indistinguishable.
    if ((TAG_BASE & 8'((1 << IDX_W) - 1)) != 8'h00) begin : g_tag_overlap
        $warning("uart_tx_arbiter: TAG_BASE low bits overlap the requester index");
    end

`ifdef UART_ARB_SRC_TAG_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TAG   = 3'd1,
        S_FETCH = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4
    } state_t;
`endif

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic               last_reg, last_next;
    logic               blank_reg, blank_next;
    logic [7:0]         data_reg, data_next;
    logic               start_reg;

    logic [7:0]         lane_data [NUM_REQ];
    logic               fetch_open;
    logic               sel_valid;
    logic               handshake;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;

    assign fetch_open = (state_reg == S_FETCH) && !uart_busy;
    assign sel_valid  = req_valid[idx_reg];
    assign handshake  = fetch_open && sel_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_data[gi] = req_data[8*gi +: 8];
            assign req_ready[gi] = fetch_open && (idx_reg == IDX_W'(gi)) && req_valid[gi];
        end
    endgenerate

    // Round-robin search starting just after the last served requester; the
    // descending loop leaves the nearest valid candidate as the final winner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        last_next  = last_reg;
        blank_next = blank_reg;
        data_next  = data_reg;
        case (state_reg)
            S_IDLE: begin
                if (pick_found) begin
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    idx_next             = pick_idx;
`ifdef UART_ARB_SRC_TAG_EN
                    state_next           = S_TAG;
`else
                    state_next           = S_FETCH;
`endif
                end
            end
`ifdef UART_ARB_SRC_TAG_EN
            S_TAG: begin
                if (!uart_busy) begin
                    data_next  = TAG_BASE | 8'(idx_reg);
                    last_next  = 1'b0;
                    state_next = S_START;
                end
            end
`endif
            S_FETCH: begin
                if (handshake) begin
                    data_next  = lane_data[idx_reg];
                    last_next  = req_last[idx_reg];
                    state_next = S_START;
                end
            end
            S_START: begin
                blank_next = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // The core may not raise busy until a cycle after start, so the
                // first WAIT cycle never trusts a low busy.
                if (blank_reg) begin
                    blank_next = 1'b0;
                end else if (!uart_busy) begin
                    if (last_reg) begin
                        ptr_next   = idx_reg;
                        grant_next = '0;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            default: begin
                grant_next = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            grant_reg <= '0;
            idx_reg   <= '0;
            ptr_reg   <= IDX_W'(NUM_REQ - 1);
            last_reg  <= 1'b0;
            blank_reg <= 1'b0;
            data_reg  <= 8'h00;
            start_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
            last_reg  <= last_next;
            blank_reg <= blank_next;
            data_reg  <= data_next;
            start_reg <= (state_next == S_START);
        end
    end

    assign grant      = grant_reg;
    assign active     = |grant_reg;
    assign uart_data  = data_reg;
    assign uart_start = start_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple UART busy model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int FRAME_LEN = 10;
`ifdef UART_ARB_SRC_TAG_EN
    localparam int TAG_ON = 1;
`else
    localparam int TAG_ON = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_data;
    logic                 uart_start;
    logic                 uart_busy;
    logic [NUM_REQ-1:0]   grant;
    logic                 active;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TAG_BASE(8'hA0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .uart_data (uart_data),
        .uart_start(uart_start),
        .uart_busy (uart_busy),
        .grant     (grant),
        .active    (active)
    );

    // Per-lane byte FIFOs: stimulus writes, the driver process pops on handshake.
    logic [7:0]         lane_byte [NUM_REQ][16];
    logic               lane_lst  [NUM_REQ][16];
    logic [3:0]         rd_ptr    [NUM_REQ] = '{default: '0};
    logic [3:0]         wr_ptr    [NUM_REQ] = '{default: '0};
    logic [NUM_REQ-1:0] en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_src
            assign req_valid[gi]        = en[gi] && (rd_ptr[gi] != wr_ptr[gi]);
            assign req_data[8*gi +: 8]  = lane_byte[gi][rd_ptr[gi]];
            assign req_last[gi]         = lane_lst[gi][rd_ptr[gi]];
        end
    endgenerate

    int   busy_cnt = 0;
    logic busy_force;
    assign uart_busy = busy_force || (busy_cnt != 0);

    logic               start_seen = 1'b0;
    logic [NUM_REQ-1:0] ready_seen = '0;
    logic [7:0]         log_data  [64];
    logic [NUM_REQ-1:0] log_grant [64];
    int                 n_starts = 0;
    int                 ready_cnt [NUM_REQ] = '{default: 0};
    logic               watch_stall, watch_busy;
    int                 stall_bad = 0;
    int                 busy_bad = 0;

    always @(negedge clk) begin
        start_seen = uart_start;
        ready_seen = req_ready;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) ready_cnt[i]++;
        if (uart_start && n_starts < 64) begin
            log_data[n_starts]  = uart_data;
            log_grant[n_starts] = grant;
            n_starts++;
        end
        if (watch_stall && (grant != 4'b1000 || uart_start)) stall_bad++;
        if (watch_busy && (req_ready != '0 || uart_start)) busy_bad++;
    end

    // Core model goes busy the cycle after start; requesters pop after the consuming edge.
    always @(posedge clk) begin
        #1;
        if (start_seen) busy_cnt = FRAME_LEN;
        else if (busy_cnt > 0) busy_cnt--;
        for (int i = 0; i < NUM_REQ; i++) if (ready_seen[i]) rd_ptr[i] = rd_ptr[i] + 4'd1;
    end

    int                 n_checks = 0;
    int                 n_fail = 0;
    logic [7:0]         exp_data  [64];
    logic [NUM_REQ-1:0] exp_grant [64];
    int                 n_exp = 0;
    int                 n_verified = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("pass %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int lane, input logic [7:0] b, input logic l);
        lane_byte[lane][wr_ptr[lane]] = b;
        lane_lst[lane][wr_ptr[lane]]  = l;
        wr_ptr[lane] = wr_ptr[lane] + 4'd1;
    endtask

    task automatic exp_byte(input int lane, input logic [7:0] b);
        exp_data[n_exp]  = b;
        exp_grant[n_exp] = 4'(1 << lane);
        n_exp++;
    endtask

    task automatic exp_tag(input int lane);
        if (TAG_ON != 0) exp_byte(lane, 8'hA0 | 8'(lane));
    endtask

    function automatic logic lanes_pending();
        logic p = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (rd_ptr[i] != wr_ptr[i]) p = 1'b1;
        return p;
    endfunction

    task automatic wait_starts(input int target);
        int budget = 3000;
        while (n_starts < target && budget > 0) begin
            tick();
            budget--;
        end
        check_val("start_count_reached", 32'(n_starts >= target), 32'd1);
    endtask

    task automatic wait_idle();
        int budget = 3000;
        while ((active || lanes_pending()) && budget > 0) begin
            tick();
            budget--;
        end
        check_val("idle_reached", 32'(active), 32'd0);
    endtask

    task automatic verify_log();
        for (int k = n_verified; k < n_exp; k++) begin
            check_val($sformatf("start%0d_data", k), 32'(log_data[k]), 32'(exp_data[k]));
            check_val($sformatf("start%0d_grant", k), 32'(log_grant[k]), 32'(exp_grant[k]));
        end
        n_verified = n_exp;
        check_val("start_total", n_starts, n_exp);
    endtask

    initial begin
        int target;
        int s0;
        rst = 1'b1;
        en = '0;
        busy_force = 1'b0;
        watch_stall = 1'b0;
        watch_busy = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_val("rst_uart_start", 32'(uart_start), 32'd0);
        check_val("rst_uart_data", 32'(uart_data), 32'h00);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_active", 32'(active), 32'd0);
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single 3-byte packet on req0, with first-byte latency checks.
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
        en[0] = 1'b1;
        exp_tag(0); exp_byte(0, 8'h11); exp_byte(0, 8'h22); exp_byte(0, 8'h33);
        @(posedge clk);
        @(negedge clk);
        check_val("grant_latency", 32'(grant), 32'b0001);
        check_val("ready_first", 32'(req_ready), (TAG_ON != 0) ? 32'd0 : 32'b0001);
        @(negedge clk);
        check_val("start_after_hs", 32'(uart_start), 32'd1);
        check_val("data_after_hs", 32'(uart_data), (TAG_ON != 0) ? 32'hA0 : 32'h11);
        wait_starts(n_exp);
        wait_idle();
        verify_log();
        check_val("ready0_pulses", ready_cnt[0], 3);
        check_val("grant_released", 32'(grant), 32'd0);

        // Contention between req1 and req2 from reset, then repeated.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b1);
        push(2, 8'h51, 1'b0); push(2, 8'h52, 1'b1);
        en[1] = 1'b1; en[2] = 1'b1;
        exp_tag(1); exp_byte(1, 8'h41); exp_byte(1, 8'h42);
        exp_tag(2); exp_byte(2, 8'h51); exp_byte(2, 8'h52);
        wait_starts(n_exp);
        wait_idle();
        verify_log();
        push(1, 8'h43, 1'b0); push(1, 8'h44, 1'b1);
        push(2, 8'h53, 1'b0); push(2, 8'h54, 1'b1);
        exp_tag(1); exp_byte(1, 8'h43); exp_byte(1, 8'h44);
        exp_tag(2); exp_byte(2, 8'h53); exp_byte(2, 8'h54);
        wait_starts(n_exp);
        wait_idle();
        verify_log();

        // Stall: req3 drops valid mid-packet while req0 waits.
        target = n_starts + TAG_ON + 2;
        push(3, 8'h61, 1'b0); push(3, 8'h62, 1'b0); push(3, 8'h63, 1'b0); push(3, 8'h64, 1'b1);
        push(0, 8'h71, 1'b1);
        en[3] = 1'b1;
        exp_tag(3); exp_byte(3, 8'h61); exp_byte(3, 8'h62); exp_byte(3, 8'h63); exp_byte(3, 8'h64);
        exp_tag(0); exp_byte(0, 8'h71);
        wait_starts(target);
        en[3] = 1'b0;
        watch_stall = 1'b1;
        s0 = n_starts;
        repeat (20) tick();
        watch_stall = 1'b0;
        check_val("stall_no_start", n_starts, s0);
        check_val("stall_bad_cycles", stall_bad, 0);
        check_val("stall_grant", 32'(grant), 32'b1000);
        en[3] = 1'b1;
        wait_starts(n_exp);
        wait_idle();
        verify_log();

        // Long busy: nothing may move while the core reports busy.
        busy_force = 1'b1;
        push(0, 8'h81, 1'b1);
        exp_tag(0); exp_byte(0, 8'h81);
        watch_busy = 1'b1;
        repeat (100) tick();
        watch_busy = 1'b0;
        check_val("busy_bad_cycles", busy_bad, 0);
        check_val("busy_grant", 32'(grant), 32'b0001);
        busy_force = 1'b0;
        @(negedge clk);
        check_val("busy_release_ready", 32'(req_ready), (TAG_ON != 0) ? 32'd0 : 32'b0001);
        @(negedge clk);
        check_val("busy_release_start", 32'(uart_start), 32'd1);
        check_val("busy_release_data", 32'(uart_data), (TAG_ON != 0) ? 32'hA0 : 32'h81);
        wait_starts(n_exp);
        wait_idle();
        verify_log();

        // Reset after the 2nd of 4 bytes; req0 must win the next arbitration.
        target = n_starts + TAG_ON + 2;
        push(3, 8'h91, 1'b0); push(3, 8'h92, 1'b0); push(3, 8'h93, 1'b0); push(3, 8'h94, 1'b1);
        exp_tag(3); exp_byte(3, 8'h91); exp_byte(3, 8'h92);
        wait_starts(target);
        push(0, 8'hA5, 1'b1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_val("midrst_uart_start", 32'(uart_start), 32'd0);
        check_val("midrst_uart_data", 32'(uart_data), 32'h00);
        check_val("midrst_grant", 32'(grant), 32'd0);
        check_val("midrst_active", 32'(active), 32'd0);
        check_val("midrst_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        exp_tag(0); exp_byte(0, 8'hA5);
        exp_tag(3); exp_byte(3, 8'h93); exp_byte(3, 8'h94);
        wait_starts(n_exp);
        wait_idle();
        verify_log();

        // Single-byte packet on req2 (preceded by its tag when tagging is built in).
        push(2, 8'h5A, 1'b1);
        exp_tag(2); exp_byte(2, 8'h5A);
        wait_starts(n_exp);
        wait_idle();
        repeat (5) tick();
        verify_log();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
